cardinal_router_local_port: RTL and testbench

Router-side endpoint of the cardinal NIC link: the block that sits across the `net_*` wires from `cardinal_nic` and forms the local (PE) port of a cardinal router. It generates `net_polarity` and accepts NIC-sourced packets into per-VC ingress buffers, then forwards them to the router crossbar. It also accepts crossbar packets into per-VC egress buffers and delivers them to the NIC. All buffering obeys the even/odd polarity VC discipline: external link on VC `~polarity`, internal crossbar transfer on VC `polarity`.

---
 rtl/cardinal_pkg.sv | 19 +
 rtl/cardinal_vc_buf2.sv | 38 +++
 rtl/cardinal_router_local_port.sv | 104 ++++++++++
 tb/tb_cardinal_router_local_port.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cardinal_pkg.sv
// Shared constants for the cardinal NIC link: packet layout and default widths.
package cardinal_pkg;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int DEFAULT_CNT_WIDTH  = 16;

    // Packet layout for the default 64-bit link.
    localparam int VC_BIT      = DEFAULT_DATA_WIDTH - 1;
    localparam int DIR_BIT     = DEFAULT_DATA_WIDTH - 2;
    localparam int HOP_MSB     = 55;
    localparam int HOP_LSB     = 48;
    localparam int SRC_MSB     = 47;
    localparam int SRC_LSB     = 32;
    localparam int PAYLOAD_MSB = 31;
    localparam int PAYLOAD_LSB = 0;

    typedef enum logic {VC_EVEN = 1'b0, VC_ODD = 1'b1} vc_e;

endpackage

// File: rtl/cardinal_vc_buf2.sv
// Two one-entry VC slots; a slot is written on one polarity phase and read on the other.
module cardinal_vc_buf2
    import cardinal_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  wr_vc,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  rd_vc,
    output logic [1:0]            full,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [1:0][DATA_WIDTH-1:0] data;

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= '0;
            data <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_en && (wr_vc == 1'(i))) begin
                    full[i] <= 1'b1;
                    data[i] <= wr_data;
                end else if (rd_en && (rd_vc == 1'(i))) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    assign rd_data = data[rd_vc];

endmodule

// File: rtl/cardinal_router_local_port.sv
// Router-side local port of the cardinal NIC link: polarity generation, per-VC
// ingress/egress buffering, VC checking and packet counters.
module cardinal_router_local_port
    import cardinal_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  net_polarity,
    input  logic                  net_so,
    output logic                  net_ro,
    input  logic [DATA_WIDTH-1:0] net_do,
    output logic                  net_si,
    input  logic                  net_ri,
    output logic [DATA_WIDTH-1:0] net_di,
    output logic                  xo_v,
    input  logic                  xo_r,
    output logic [DATA_WIDTH-1:0] xo_d,
    input  logic                  xi_v,
    output logic                  xi_r,
    input  logic [DATA_WIDTH-1:0] xi_d,
    output logic                  err_vc,
    output logic [CNT_WIDTH-1:0]  rx_cnt,
    output logic [CNT_WIDTH-1:0]  tx_cnt
);

    localparam int MSB = DATA_WIDTH - 1;

    logic                  pol;
    logic                  ext_vc;
    logic                  int_vc;
    logic [1:0]            ib_full;
    logic [1:0]            eb_full;
    logic [DATA_WIDTH-1:0] ib_rd_data;
    logic [DATA_WIDTH-1:0] eb_rd_data;
    logic                  nic_offer;
    logic                  nic_acc;
    logic                  xo_pop;
    logic                  xb_acc;
    logic                  ni_pop;

    // The link runs on VC ~pol while the crossbar side uses VC pol, so the
    // slot filled this cycle is the one drained next cycle.
    assign ext_vc       = ~pol;
    assign int_vc       = pol;
    assign net_polarity = pol;

    assign net_ro    = ~reset & ~ib_full[ext_vc];
    assign nic_offer = net_so & net_ro;
    assign nic_acc   = nic_offer & (net_do[MSB] == ext_vc);

    assign xo_v   = ib_full[int_vc];
    assign xo_d   = ib_rd_data;
    assign xo_pop = xo_v & xo_r;

    // A wrong-VC crossbar offer is simply not taken; the crossbar retries.
    assign xi_r   = ~reset & ~eb_full[int_vc];
    assign xb_acc = xi_v & xi_r & (xi_d[MSB] == int_vc);

    assign net_si = eb_full[ext_vc];
    assign net_di = eb_rd_data;
    assign ni_pop = net_si & net_ri;

    always_ff @(posedge clk) begin
        if (reset) begin
            pol    <= 1'b0;
            err_vc <= 1'b0;
            rx_cnt <= '0;
            tx_cnt <= '0;
        end else begin
            pol    <= ~pol;
            err_vc <= nic_offer & (net_do[MSB] != ext_vc);
            if (nic_acc) rx_cnt <= rx_cnt + CNT_WIDTH'(1);
            if (ni_pop)  tx_cnt <= tx_cnt + CNT_WIDTH'(1);
        end
    end

    cardinal_vc_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_ingress (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (nic_acc),
        .wr_vc   (ext_vc),
        .wr_data (net_do),
        .rd_en   (xo_pop),
        .rd_vc   (int_vc),
        .full    (ib_full),
        .rd_data (ib_rd_data)
    );

    cardinal_vc_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_egress (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (xb_acc),
        .wr_vc   (int_vc),
        .wr_data (xi_d),
        .rd_en   (ni_pop),
        .rd_vc   (ext_vc),
        .full    (eb_full),
        .rd_data (eb_rd_data)
    );

endmodule

// File: tb/tb_cardinal_router_local_port.sv
// Bench for cardinal_router_local_port: directed steps plus random traffic against
// a per-VC slot model of the link, with NIC/crossbar drivers that hold until accepted.
module tb_cardinal_router_local_port;

    localparam int DW = 64;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          net_so = 1'b0, net_ri = 1'b0, xo_r = 1'b0, xi_v = 1'b0;
    logic [DW-1:0] net_do = '0, xi_d = '0;
    logic          net_polarity, net_ro, net_si, xo_v, xi_r, err_vc;
    logic [DW-1:0] net_di, xo_d;
    logic [CW-1:0] rx_cnt, tx_cnt;

    always #5 clk = ~clk;

    cardinal_router_local_port dut (
        .clk(clk), .reset(reset), .net_polarity(net_polarity),
        .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_si(net_si), .net_ri(net_ri), .net_di(net_di),
        .xo_v(xo_v), .xo_r(xo_r), .xo_d(xo_d),
        .xi_v(xi_v), .xi_r(xi_r), .xi_d(xi_d),
        .err_vc(err_vc), .rx_cnt(rx_cnt), .tx_cnt(tx_cnt)
    );

    int tests = 0;
    int fails = 0;

    // Reference: one packet slot per VC on each path, polarity as a toggling bit.
    bit          mpol = 1'b0, merr = 1'b0;
    bit          ibf[2], ebf[2];
    logic [63:0] ibd[2], ebd[2];
    logic [15:0] mrx = '0, mtx = '0;
    logic [63:0] nic_q[$], xb_q[$], xo_log[$], ni_log[$];
    int          nic_pushed = 0, xb_pushed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic nic_push(input logic [63:0] p);
        nic_q.push_back(p);
        nic_pushed++;
    endtask

    task automatic xb_push(input logic [63:0] p);
        xb_q.push_back(p);
        xb_pushed++;
    endtask

    // One clock: drive queue heads, check outputs against the model, advance the model.
    task automatic cyc();
        bit e, i, nacc, nerr, xpop, xacc, npop;
        net_so = (nic_q.size() != 0);
        net_do = net_so ? nic_q[0] : '0;
        xi_v   = (xb_q.size() != 0);
        xi_d   = xi_v ? xb_q[0] : '0;
        #2;
        e = ~mpol;
        i = mpol;
        chk("pol", net_polarity, mpol);
        chk("net_ro", net_ro, !reset && !ibf[e]);
        chk("xi_r", xi_r, !reset && !ebf[i]);
        chk("xo_v", xo_v, ibf[i]);
        if (ibf[i]) chk("xo_d", xo_d, ibd[i]);
        chk("net_si", net_si, ebf[e]);
        if (ebf[e]) chk("net_di", net_di, ebd[e]);
        chk("err_vc", err_vc, merr);
        chk("rx_cnt", rx_cnt, mrx);
        chk("tx_cnt", tx_cnt, mtx);
        if (reset) begin
            mpol = 0; merr = 0; mrx = '0; mtx = '0;
            ibf[0] = 0; ibf[1] = 0; ebf[0] = 0; ebf[1] = 0;
        end else begin
            nacc = net_so && !ibf[e] && (net_do[63] == e);
            nerr = net_so && !ibf[e] && (net_do[63] != e);
            xpop = xo_r && ibf[i];
            xacc = xi_v && !ebf[i] && (xi_d[63] == i);
            npop = net_ri && ebf[e];
            if (nacc) begin
                ibf[e] = 1; ibd[e] = net_do; mrx = mrx + 16'd1;
                void'(nic_q.pop_front());
            end
            if (xpop) begin xo_log.push_back(ibd[i]); ibf[i] = 0; end
            if (xacc) begin
                ebf[i] = 1; ebd[i] = xi_d;
                void'(xb_q.pop_front());
            end
            if (npop) begin ni_log.push_back(ebd[e]); ebf[e] = 0; mtx = mtx + 16'd1; end
            merr = nerr;
            mpol = ~mpol;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((nic_q.size() != 0 || xb_q.size() != 0 || ibf[0] || ibf[1] || ebf[0] || ebf[1])
               && k < 200) begin
            cyc();
            k++;
        end
        chk(tag, k < 200, 1);
    endtask

    initial begin
        logic [63:0] s0[$], s1[$];
        logic [63:0] p, exp_p;
        int start;

        ibf[0] = 0; ibf[1] = 0; ebf[0] = 0; ebf[1] = 0;
        @(posedge clk);
        #1;
        repeat (4) cyc();
        chk("rst_pol", net_polarity, 0);
        chk("rst_xo_v", xo_v, 0);
        chk("rst_net_si", net_si, 0);
        chk("rst_xo_d", xo_d, 0);
        chk("rst_net_di", net_di, 0);
        chk("rst_rx", rx_cnt, 0);

        // First cycle out of reset accepts a VC1 packet.
        reset = 0;
        xo_r  = 1;
        #1;
        chk("first_pol", net_polarity, 0);
        chk("first_ro", net_ro, 1);
        nic_push(64'h8000_0000_0000_0001);
        cyc();
        chk("first_rx", rx_cnt, 1);
        chk("first_xo_v", xo_v, 1);
        chk("first_xo_d", xo_d, 64'h8000_0000_0000_0001);
        cyc();

        // Wrong-VC offer at pol=0 pulses err_vc, then the held packet is taken.
        nic_push(64'h1);
        cyc();
        chk("err_pulse", err_vc, 1);
        chk("err_rx", rx_cnt, 1);
        cyc();
        chk("err_clear", err_vc, 0);
        chk("err_accept", rx_cnt, 2);
        cyc();

        // Crossbar stalled: only one packet per VC fits.
        xo_r  = 0;
        start = xo_log.size();
        for (int k = 0; k < 10; k++) begin
            p = 64'(100 + k);
            p[63] = k[0];
            nic_push(p);
            if (k[0]) s1.push_back(p); else s0.push_back(p);
        end
        repeat (8) cyc();
        chk("bp_rx", rx_cnt, 4);
        chk("bp_ro", net_ro, 0);
        xo_r = 1;
        drain("bp_drain");
        chk("bp_rx_all", rx_cnt, 12);
        chk("bp_cnt", xo_log.size() - start, 10);
        for (int k = start; k < xo_log.size(); k++) begin
            exp_p = xo_log[k][63] ? s1.pop_front() : s0.pop_front();
            chk("bp_order", xo_log[k], exp_p);
        end

        // Crossbar to NIC, ten packets with alternating VC.
        net_ri = 1;
        start  = ni_log.size();
        for (int k = 0; k < 10; k++) begin
            p = 64'(k);
            p[63] = k[0];
            xb_push(p);
        end
        drain("eg_drain");
        chk("eg_tx", tx_cnt, 10);
        chk("eg_cnt", ni_log.size() - start, 10);
        for (int k = 0; k < 10; k++) begin
            exp_p = 64'(k);
            exp_p[63] = k[0];
            if (start + k < ni_log.size()) chk("eg_order", ni_log[start + k], exp_p);
        end

        // Saturated random traffic on both paths.
        for (int c = 0; c < 1000; c++) begin
            if (nic_q.size() == 0) nic_push({$urandom, $urandom});
            if (xb_q.size() == 0) xb_push({$urandom, $urandom});
            xo_r   = ($urandom % 4) != 0;
            net_ri = $urandom % 2;
            cyc();
        end
        xo_r   = 1;
        net_ri = 1;
        drain("rnd_drain");
        chk("rnd_xo_total", xo_log.size(), nic_pushed);
        chk("rnd_ni_total", ni_log.size(), xb_pushed);
        chk("rnd_rx", rx_cnt, 16'(nic_pushed));
        chk("rnd_tx", tx_cnt, 16'(xb_pushed));

        // Fill every slot, then reset over the top of it.
        xo_r   = 0;
        net_ri = 0;
        nic_push({1'b1, 63'h11});
        nic_push({1'b0, 63'h22});
        xb_push({1'b1, 63'h33});
        xb_push({1'b0, 63'h44});
        repeat (4) cyc();
        chk("full_ro", net_ro, 0);
        chk("full_xi_r", xi_r, 0);
        chk("full_xo_v", xo_v, 1);
        chk("full_net_si", net_si, 1);
        reset = 1;
        cyc();
        chk("mid_rst_net_si", net_si, 0);
        chk("mid_rst_xo_v", xo_v, 0);
        chk("mid_rst_rx", rx_cnt, 0);
        chk("mid_rst_tx", tx_cnt, 0);
        chk("mid_rst_pol", net_polarity, 0);
        chk("mid_rst_xo_d", xo_d, 0);
        reset  = 0;
        xo_r   = 1;
        net_ri = 1;
        repeat (4) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
